int_ctrl: RTL and testbench

- Interrupt controller that sequences the cpu's program flow from four external event sources, one per I/O port p0..p3.
- Latches rising-edge events into pending bits and applies a software-programmable mask.
- Selects the highest-priority source and drives a vectored request/acknowledge/return handshake into the cpu.
- Sits beside the cpu on the same clock; its configuration registers are mapped into the cpu's port space.

---
 rtl/int_pkg.sv | 31 +++
 rtl/int_prio_enc.sv | 29 ++
 rtl/int_ctrl.sv | 155 +++++++++++++++
 tb/tb_int_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_pkg
//  Description : Shared definitions for the interrupt controller: handshake
//                state encodings, configuration register addresses and the
//                global-interrupt-enable bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_pkg;

  // Handshake state encodings; the two-bit value is visible in STATUS[7:6].
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Configuration register map.
  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_SWSET  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Global interrupt enable lives in MASK[7].
  localparam int GIE_BIT = 7;

  // Width of the source id carried on int_id.
  localparam int ID_W = 2;

endpackage : int_pkg
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : int_prio_enc
//  Description : Combinational fixed-priority encoder, lowest index wins.
//  Ports       : i_req  - request vector
//                o_any  - at least one request is set
//                o_id   - index of the lowest set request (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module int_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  output logic           o_any,
  output logic [IDW-1:0] o_id
);

  always_comb begin
    o_any = |i_req;
    o_id  = '0;
    // Scan from the top down so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = IDW'(i);
    end
  end

endmodule : int_prio_enc
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Four-source vectored interrupt controller. Rising edges on
//                irq are latched into pending bits, qualified by a per-source
//                mask and a global enable, and the lowest eligible index is
//                presented to the cpu through a req/ack/done handshake.
//  Ports       : clk, reset (async, active low)
//                irq        - event lines, rising edge is the event
//                cfg_*      - register port (MASK/PENDING/SWSET/STATUS)
//                int_req    - request to cpu, int_vec/int_id valid with it
//                int_ack    - cpu took the vector
//                int_done   - cpu returned from the handler
//                in_service - a handler is running
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
  import int_pkg::*;
#(
  parameter int               NSRC       = 4,
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3F0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             in_service,
  output logic [ID_W-1:0]  int_id
);

  state_t            r_state;
  logic [NSRC-1:0]   r_irq_q;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_en;
  logic              r_gie;

  logic [NSRC-1:0]   w_elig;
  logic              w_any;
  logic [ID_W-1:0]   w_enc_id;
  logic [NSRC-1:0]   w_set;
  logic [NSRC-1:0]   w_clr;
  logic [NSRC-1:0]   w_pend_nxt;
  logic              w_ack_take;
  logic [VEC_W-1:0]  w_vec_nxt;
  logic              w_unused_ok;

  assign w_elig = r_pend & r_en & {NSRC{r_gie}};

  int_prio_enc #(
    .N   (NSRC),
    .IDW (ID_W)
  ) u_prio_enc (
    .i_req (w_elig),
    .o_any (w_any),
    .o_id  (w_enc_id)
  );

  assign w_ack_take = (r_state == ST_REQ) && int_ack;
  assign w_vec_nxt  = VEC_BASE + VEC_W'(w_enc_id) * VEC_W'(VEC_STRIDE);

  // Pending update: clears are applied first, then sets, so a set in the
  // same cycle always survives.
  always_comb begin
    w_set = (irq & ~r_irq_q);
    w_clr = '0;
    if (cfg_we && cfg_addr == ADDR_SWSET) w_set = w_set | cfg_wdata[NSRC-1:0];
    if (cfg_we && cfg_addr == ADDR_PEND)  w_clr = cfg_wdata[NSRC-1:0];
    if (w_ack_take)                        w_clr[int_id] = 1'b1;
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      ADDR_MASK:   cfg_rdata = {r_gie, {(7-NSRC){1'b0}}, r_en};
      ADDR_PEND:   cfg_rdata = {{(8-NSRC){1'b0}}, r_pend};
      ADDR_SWSET:  cfg_rdata = 8'h00;
      ADDR_STATUS: cfg_rdata = {r_state, {(6-ID_W){1'b0}}, int_id};
      default:     cfg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_q <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_gie   <= 1'b0;
    end else begin
      r_irq_q <= irq;
      r_pend  <= w_pend_nxt;
      if (cfg_we && cfg_addr == ADDR_MASK) begin
        r_en  <= cfg_wdata[NSRC-1:0];
        r_gie <= cfg_wdata[GIE_BIT];
      end
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      int_vec    <= VEC_BASE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_REQ;
            int_req <= 1'b1;
            int_id  <= w_enc_id;
            int_vec <= w_vec_nxt;
          end
        end
        ST_REQ: begin
          // The ack takes precedence over a concurrent loss of eligibility.
          if (int_ack) begin
            r_state    <= ST_SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (!w_elig[int_id]) begin
            r_state <= ST_IDLE;
            int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            r_state    <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  assign w_unused_ok = ^cfg_wdata[GIE_BIT-1:NSRC];

endmodule : int_ctrl
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Directed self-checking bench for int_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       int_req;
  logic [9:0] int_vec;
  logic       int_ack;
  logic       int_done;
  logic       in_service;
  logic [1:0] int_id;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .in_service (in_service),
    .int_id     (int_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
    cfg_addr = 2'd0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v;
    cyc();
    irq = 4'h0;
  endtask

  task automatic ack();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1; cyc(); int_done = 1'b0;
  endtask

  logic [7:0] r;

  initial begin
    reset = 1'b0; irq = 4'h0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    int_ack = 1'b0; int_done = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();

    // Reset state
    chk("rst_req", int_req, 1'b0);
    chk("rst_insvc", in_service, 1'b0);
    chk("rst_id", int_id, 2'd0);
    chk("rst_vec", int_vec, 10'h3F0);
    rd(2'd0, r); chk("rst_mask", r, 8'h00);
    rd(2'd3, r); chk("rst_status", r, 8'h00);

    // Single source 0
    wr(2'd0, 8'h81);
    rd(2'd0, r); chk("mask_rb", r, 8'h81);
    pulse_irq(4'b0001);
    rd(2'd1, r); chk("t1_pend", r, 8'h01);
    chk("t1_req_early", int_req, 1'b0);
    cyc();
    chk("t1_req", int_req, 1'b1);
    chk("t1_vec", int_vec, 10'h3F0);
    rd(2'd3, r); chk("t1_status", r, 8'h40);
    ack();
    chk("t1_insvc", in_service, 1'b1);
    chk("t1_req_off", int_req, 1'b0);
    rd(2'd1, r); chk("t1_pend_clr", r, 8'h00);
    done();
    chk("t1_done", in_service, 1'b0);

    // Simultaneous sources 3 and 1
    wr(2'd0, 8'h8F);
    pulse_irq(4'b1010);
    rd(2'd1, r); chk("t2_pend", r, 8'h0A);
    cyc();
    chk("t2_id1", int_id, 2'd1);
    chk("t2_vec1", int_vec, 10'h3F4);
    ack();
    done();
    cyc();
    chk("t2_req3", int_req, 1'b1);
    chk("t2_id3", int_id, 2'd3);
    chk("t2_vec3", int_vec, 10'h3FC);
    ack();
    done();

    // GIE off holds pending without a request
    wr(2'd0, 8'h04);
    pulse_irq(4'b0100);
    cyc(); cyc();
    rd(2'd1, r); chk("t3_pend", r, 8'h04);
    chk("t3_noreq", int_req, 1'b0);
    wr(2'd0, 8'h84);
    cyc();
    chk("t3_req", int_req, 1'b1);
    chk("t3_vec", int_vec, 10'h3F8);
    chk("t3_id", int_id, 2'd2);

    // W1C withdraws the request
    wr(2'd1, 8'h04);
    cyc();
    chk("t4_req_drop", int_req, 1'b0);
    rd(2'd3, r); chk("t4_status", r, 8'h02);
    rd(2'd1, r); chk("t4_pend", r, 8'h00);
    cyc();
    chk("t4_no_svc", in_service, 1'b0);
    chk("t4_still_idle", int_req, 1'b0);

    // Edge and stray ack during service
    wr(2'd0, 8'h8F);
    pulse_irq(4'b0010);
    cyc();
    chk("t5_req1", int_req, 1'b1);
    ack();
    chk("t5_svc", in_service, 1'b1);
    irq = 4'b0001; int_ack = 1'b1;
    cyc();
    irq = 4'b0000; int_ack = 1'b0;
    chk("t5_stray_svc", in_service, 1'b1);
    chk("t5_stray_req", int_req, 1'b0);
    rd(2'd3, r); chk("t5_status", r, 8'h81);
    rd(2'd1, r); chk("t5_pend", r, 8'h01);
    done();
    chk("t5_idle", in_service, 1'b0);
    cyc();
    chk("t5_req0", int_req, 1'b1);
    chk("t5_id0", int_id, 2'd0);
    chk("t5_vec0", int_vec, 10'h3F0);
    ack();
    chk("t5_svc2", in_service, 1'b1);

    // Asynchronous reset mid-service
    wr(2'd2, 8'h04);
    rd(2'd1, r); chk("t6_swset", r, 8'h04);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_insvc", in_service, 1'b0);
    chk("t6_req", int_req, 1'b0);
    rd(2'd1, r); chk("t6_pend", r, 8'h00);
    rd(2'd0, r); chk("t6_mask", r, 8'h00);
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_after", int_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_int_ctrl
`default_nettype wire
